// File: rtl/netlist_streamer.sv
// netlist_streamer: buffers header fields and gate records, then on commit streams
// a start pulse followed by a gap-free run of 32-bit netlist words to the loader.
module netlist_streamer #(
    parameter int S  = 14,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    input  logic [S-1:0]  cfg_init_a,
    input  logic [S-1:0]  cfg_init_b,
    input  logic [S-1:0]  cfg_in_a,
    input  logic [S-1:0]  cfg_in_b,
    input  logic [S-1:0]  cfg_dff_size,
    input  logic [S-1:0]  cfg_output_size,
    input  logic [S-1:0]  cfg_gate_size,
    input  logic [S-1:0]  cfg_num_xor,
    input  logic          g_valid,
    output logic          g_ready,
    input  logic          g_is_output,
    input  logic [3:0]    g_logic,
    input  logic [S-1:0]  g_in0,
    input  logic [S-1:0]  g_in1,
    input  logic          commit,
    input  logic          clr,
    output logic          start,
    output logic [31:0]   netlist_out,
    output logic          busy,
    output logic          done,
    output logic [DW:0]   rec_count,
    output logic          err_count,
    output logic          err_range
);
    typedef enum logic [2:0] {IDLE, START, HDR, BODY, FIN} state_t;
    localparam int CW = (S > DW) ? S + 1 : DW + 1;
    localparam logic [DW:0]   ONE_C = 1;
    localparam logic [DW-1:0] ONE_P = 1;

    state_t        r_state;
    logic [S-1:0]  r_init_a, r_init_b, r_in_a, r_in_b, r_dff, r_out, r_gate, r_xor;
    logic [1:0]    r_idx;
    logic [DW:0]   r_left;
    logic [DW-1:0] r_ptr;
    logic [31:0]   r_rd;
    logic [31:0]   r_mem [2**DW];

    logic          w_acc, w_oor, w_match, w_re;
    logic [31:0]   w_gword;
    logic [31:0]   w_hdr [4];
    logic [S-1:0]  w_dff, w_gate;
    logic [DW:0]   w_cnt_next;
    logic [CW-1:0] w_expect;

    assign g_ready    = rst && (r_state == IDLE) && !rec_count[DW];
    assign w_acc      = g_valid && g_ready;
    assign w_oor      = (g_in0 >> (27 - S)) != '0;
    assign w_gword    = {g_in0[26-S:0], g_in1, g_logic, g_is_output};
    assign w_hdr[0]   = 32'({r_init_a, r_init_b});
    assign w_hdr[1]   = 32'({r_in_a, r_in_b});
    assign w_hdr[2]   = 32'({r_dff, r_out});
    assign w_hdr[3]   = 32'({r_xor, r_gate});
    // A header written in the commit cycle is the one the count check must see
    assign w_dff      = cfg_valid ? cfg_dff_size : r_dff;
    assign w_gate     = cfg_valid ? cfg_gate_size : r_gate;
    assign w_expect   = CW'(w_dff) + CW'(w_gate);
    assign w_cnt_next = rec_count + (w_acc ? ONE_C : '0);
    assign w_match    = CW'(w_cnt_next) == w_expect;
    assign w_re       = (r_state == START) || (r_state == HDR && r_idx == 2'd3) || (r_state == BODY);

    always_ff @(posedge clk) begin
        if (w_acc)
            r_mem[rec_count[DW-1:0]] <= w_gword;
        if (w_re)
            r_rd <= r_mem[r_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            {r_init_a, r_init_b, r_in_a, r_in_b} <= '0;
            {r_dff, r_out, r_gate, r_xor}        <= '0;
            r_idx       <= '0;
            r_left      <= '0;
            r_ptr       <= '0;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            netlist_out <= '0;
            rec_count   <= '0;
            err_count   <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        {r_init_a, r_init_b, r_in_a, r_in_b} <= {cfg_init_a, cfg_init_b, cfg_in_a, cfg_in_b};
                        {r_dff, r_out, r_gate, r_xor} <= {cfg_dff_size, cfg_output_size, cfg_gate_size, cfg_num_xor};
                    end
                    if (clr) begin
                        rec_count <= '0;
                        err_count <= 1'b0;
                        err_range <= 1'b0;
                    end else begin
                        rec_count <= w_cnt_next;
                        if (w_acc && w_oor)
                            err_range <= 1'b1;
                        if (commit && w_match) begin
                            r_state <= START;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                            r_ptr   <= '0;
                        end else if (commit)
                            err_count <= 1'b1;
                    end
                end
                START: begin
                    start       <= 1'b0;
                    r_state     <= HDR;
                    r_idx       <= '0;
                    r_ptr       <= r_ptr + ONE_P;
                    netlist_out <= w_hdr[0];
                end
                HDR: begin
                    if (r_idx != 2'd3) begin
                        netlist_out <= w_hdr[r_idx + 2'd1];
                        r_idx       <= r_idx + 2'd1;
                    end else if (rec_count == '0) begin
                        netlist_out <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        netlist_out <= r_rd;
                        r_ptr       <= r_ptr + ONE_P;
                        r_left      <= rec_count - ONE_C;
                        r_state     <= BODY;
                    end
                end
                BODY: begin
                    if (r_left == '0) begin
                        netlist_out <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        netlist_out <= r_rd;
                        r_ptr       <= r_ptr + ONE_P;
                        r_left      <= r_left - ONE_C;
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    rec_count <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_netlist_streamer.sv
// tb_netlist_streamer: scoreboard bench; a second instance with DW=2 covers the full-buffer case.
module tb_netlist_streamer;
    localparam int S = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          cfg_valid = 0, g_valid = 0, g_is_output = 0, commit = 0, clr = 0;
    logic [S-1:0]  cfg_init_a = 0, cfg_init_b = 0, cfg_in_a = 0, cfg_in_b = 0;
    logic [S-1:0]  cfg_dff_size = 0, cfg_output_size = 0, cfg_gate_size = 0, cfg_num_xor = 0;
    logic [3:0]    g_logic = 0;
    logic [S-1:0]  g_in0 = 0, g_in1 = 0;

    logic          g_ready, start, busy, done, err_count, err_range;
    logic [31:0]   netlist_out;
    logic [10:0]   rec_count;
    logic          s_g_ready, s_start, s_busy, s_done, s_err_count, s_err_range;
    logic [31:0]   s_netlist_out;
    logic [2:0]    s_rec_count;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    netlist_streamer #(.S(S), .DW(10)) u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
        .cfg_init_a(cfg_init_a), .cfg_init_b(cfg_init_b), .cfg_in_a(cfg_in_a), .cfg_in_b(cfg_in_b),
        .cfg_dff_size(cfg_dff_size), .cfg_output_size(cfg_output_size),
        .cfg_gate_size(cfg_gate_size), .cfg_num_xor(cfg_num_xor),
        .g_valid(g_valid), .g_ready(g_ready), .g_is_output(g_is_output), .g_logic(g_logic),
        .g_in0(g_in0), .g_in1(g_in1), .commit(commit), .clr(clr),
        .start(start), .netlist_out(netlist_out), .busy(busy), .done(done),
        .rec_count(rec_count), .err_count(err_count), .err_range(err_range)
    );

    netlist_streamer #(.S(S), .DW(2)) u_small (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
        .cfg_init_a(cfg_init_a), .cfg_init_b(cfg_init_b), .cfg_in_a(cfg_in_a), .cfg_in_b(cfg_in_b),
        .cfg_dff_size(cfg_dff_size), .cfg_output_size(cfg_output_size),
        .cfg_gate_size(cfg_gate_size), .cfg_num_xor(cfg_num_xor),
        .g_valid(g_valid), .g_ready(s_g_ready), .g_is_output(g_is_output), .g_logic(g_logic),
        .g_in0(g_in0), .g_in1(g_in1), .commit(commit), .clr(clr),
        .start(s_start), .netlist_out(s_netlist_out), .busy(s_busy), .done(s_done),
        .rec_count(s_rec_count), .err_count(s_err_count), .err_range(s_err_range)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] gate_word(logic o, logic [3:0] lg, logic [S-1:0] i0, logic [S-1:0] i1);
        return (32'(i0) % 32'd8192) * 32'h80000 + 32'(i1) * 32'd32 + 32'(lg) * 32'd2 + 32'(o);
    endfunction

    function automatic logic [31:0] hdr(logic [S-1:0] hi, logic [S-1:0] lo);
        return 32'(hi) * 32'd16384 + 32'(lo);
    endfunction

    task automatic set_cfg(input int ia, ib, xa, xb, dff, outs, gate, xr, input bit cm);
        cfg_init_a = S'(ia); cfg_init_b = S'(ib); cfg_in_a = S'(xa); cfg_in_b = S'(xb);
        cfg_dff_size = S'(dff); cfg_output_size = S'(outs); cfg_gate_size = S'(gate); cfg_num_xor = S'(xr);
        cfg_valid = 1; commit = cm;
        tick();
        cfg_valid = 0; commit = 0;
    endtask

    task automatic push_hdr(input int ia, ib, xa, xb, dff, outs, gate, xr);
        exp_q.push_back(hdr(S'(ia), S'(ib)));
        exp_q.push_back(hdr(S'(xa), S'(xb)));
        exp_q.push_back(hdr(S'(dff), S'(outs)));
        exp_q.push_back(hdr(S'(xr), S'(gate)));
    endtask

    task automatic push_rec(input logic o, input logic [3:0] lg, input int i0, i1, input logic [31:0] exp);
        g_valid = 1; g_is_output = o; g_logic = lg; g_in0 = S'(i0); g_in1 = S'(i1);
        check("g_ready", g_ready, 1);
        exp_q.push_back(exp);
        tick();
        g_valid = 0;
    endtask

    task automatic do_commit();
        commit = 1;
        tick();
        commit = 0;
    endtask

    task automatic run_stream(input int n);
        for (int i = 0; i < 8 && !start; i++) tick();
        check("start", start, 1);
        check("busy_start", busy, 1);
        check("out_start", netlist_out, 0);
        for (int k = 0; k < 4 + n; k++) begin
            tick();
            check($sformatf("word%0d", k), netlist_out, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEADBEEF);
            check("busy_word", {start, busy, done}, 3'b010);
        end
        tick();
        check("done", done, 1);
        check("busy_fin", busy, 0);
        check("out_fin", netlist_out, 0);
        tick();
        check("done_pulse", done, 0);
        check("rec_clr", rec_count, 0);
        check("idle_ready", g_ready, 1);
    endtask

    initial begin
        g_valid = 1;
        tick();
        tick();
        check("rst_ready", g_ready, 0);
        check("rst_flags", {start, busy, done, err_count, err_range}, 0);
        check("rst_out", netlist_out, 0);
        check("rst_count", rec_count, 0);
        g_valid = 0;
        rst = 1;
        tick();
        check("ready_after_rst", g_ready, 1);

        // Worked header example with literal expected words
        set_cfg(2, 3, 4, 5, 1, 2, 3, 1, 0);
        exp_q.push_back(32'h0000_8003);
        exp_q.push_back(32'h0001_0005);
        exp_q.push_back(32'h0000_4002);
        exp_q.push_back(32'h0000_4003);
        push_rec(1, 4'h6, 7, 9, 32'h0038_012D);
        push_rec(0, 4'h8, 1, 2, gate_word(0, 4'h8, 1, 2));
        push_rec(1, 4'h1, 100, 200, gate_word(1, 4'h1, 100, 200));
        push_rec(0, 4'hF, 8191, 16383, gate_word(0, 4'hF, 8191, 16383));
        check("count4", rec_count, 4);
        do_commit();
        run_stream(4);
        check("no_err", {err_count, err_range}, 0);

        // Count mismatch, then fix with a fifth (out-of-range) record
        set_cfg(16, 32, 1, 1, 2, 1, 3, 0, 0);
        push_hdr(16, 32, 1, 1, 2, 1, 3, 0);
        for (int i = 0; i < 4; i++)
            push_rec(i[0], 4'(i + 2), i * 3, i + 11, gate_word(i[0], 4'(i + 2), S'(i * 3), S'(i + 11)));
        do_commit();
        check("mm_no_start", start, 0);
        check("mm_err", err_count, 1);
        check("mm_busy", busy, 0);
        check("mm_ready", g_ready, 1);
        check("mm_kept", rec_count, 4);
        check("range_clean", err_range, 0);
        push_rec(1, 4'h3, 8192, 5, 32'h0000_00A7);
        check("range_err", err_range, 1);
        do_commit();
        run_stream(5);
        check("err_sticky", {err_count, err_range}, 2'b11);

        // Zero gates, header loaded in the same cycle as commit
        exp_q.push_back(32'h0FFF_FFFF);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        set_cfg(16383, 16383, 0, 0, 0, 0, 0, 0, 1);
        run_stream(0);

        // Full buffer on the DW=2 instance
        clr = 1;
        tick();
        clr = 0;
        check("clr_err", {err_count, err_range}, 0);
        check("clr_small", s_rec_count, 0);
        g_valid = 1; g_is_output = 0; g_logic = 4'h9; g_in0 = 1; g_in1 = 2;
        for (int i = 0; i < 5; i++) tick();
        g_valid = 0;
        check("full_count", s_rec_count, 4);
        check("full_ready", s_g_ready, 0);
        check("big_count", rec_count, 5);

        // Asynchronous reset in the middle of the body
        clr = 1;
        tick();
        clr = 0;
        exp_q.delete();
        set_cfg(0, 0, 0, 0, 0, 0, 3, 0, 0);
        push_hdr(0, 0, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++)
            push_rec(1, 4'hA, i + 40, i + 50, gate_word(1, 4'hA, S'(i + 40), S'(i + 50)));
        do_commit();
        for (int i = 0; i < 8 && !start; i++) tick();
        check("rb_start", start, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rb_word%0d", k), netlist_out, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEADBEEF);
        end
        check("rb_busy", busy, 1);
        #2 rst = 0;
        #1;
        check("rb_busy0", busy, 0);
        check("rb_out0", netlist_out, 0);
        check("rb_count0", rec_count, 0);
        check("rb_ready0", g_ready, 0);
        @(posedge clk);
        #1 rst = 1;
        tick();
        check("rb_ready1", g_ready, 1);
        check("rb_idle", {start, busy, done}, 0);
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
